// File: rtl/tp_pkg.sv
// Shared definitions for the tp_placar score display: result class codes,
// display FSM state encoding and the digit-to-segment table.
package tp_pkg;

  localparam logic [1:0] TIPO_NULO = 2'b00;
  localparam logic [1:0] TIPO_ADJ  = 2'b01;
  localparam logic [1:0] TIPO_COMP = 2'b10;
  localparam logic [1:0] TIPO_ADV  = 2'b11;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_DESTAQUE = 1'b1
  } disp_state_t;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 blanks the digit.
  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decod_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
module decod_7seg
  import tp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_of_digit(digit_i);

endmodule

// File: rtl/tp_placar.sv
// Per-class decimal result counters with a highlight display of the latest capture.
// Optional automatic display rotation is enabled by defining TP_PLACAR_AUTO_ROTATE_EN.
module tp_placar
  import tp_pkg::*;
#(
  parameter int DESTAQUE_CICLOS = 8,
  parameter int ROT_CICLOS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fim,
  input  logic [1:0] tipo,
  input  logic       sel,
  output logic [6:0] display,
  output logic [1:0] tipo_exibido,
  output logic       novo
);

  if (DESTAQUE_CICLOS < 1 || ROT_CICLOS < 1) begin : g_bad_param
    $error("tp_placar: DESTAQUE_CICLOS and ROT_CICLOS must be at least 1");
  end

  localparam int TW = (DESTAQUE_CICLOS > 1) ? $clog2(DESTAQUE_CICLOS) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DESTAQUE_CICLOS - 1);

  logic              fim_q, sel_q;
  logic              novo_q;
  logic [3:0]        cnt_q [4];
  logic [1:0]        sel_r_q, sel_r_d;
  logic [1:0]        tipo_dest_q;
  logic [TW-1:0]     timer_q;
  disp_state_t       state_q;
  logic              captura, passo;
  logic [3:0]        digito;

  assign captura = fim & ~fim_q;
  assign passo   = sel & ~sel_q;

`ifdef TP_PLACAR_AUTO_ROTATE_EN
  localparam int RW = (ROT_CICLOS > 1) ? $clog2(ROT_CICLOS) : 1;
  logic [RW-1:0] rot_q, rot_d;
  logic          rot_tick;

  // A manual step restarts the rotation period; the period only runs in NORMAL.
  always_comb begin
    rot_d    = rot_q;
    rot_tick = 1'b0;
    if (passo) begin
      rot_d = '0;
    end else if (state_q == ST_NORMAL) begin
      if (rot_q == RW'(ROT_CICLOS - 1)) begin
        rot_d    = '0;
        rot_tick = 1'b1;
      end else begin
        rot_d = rot_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rot_q <= '0;
    else       rot_q <= rot_d;
  end

  assign sel_r_d = sel_r_q + {1'b0, passo | rot_tick};
`else
  assign sel_r_d = sel_r_q + {1'b0, passo};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fim_q       <= 1'b0;
      sel_q       <= 1'b0;
      novo_q      <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 4'd0;
      sel_r_q     <= 2'b00;
      tipo_dest_q <= TIPO_NULO;
      timer_q     <= '0;
      state_q     <= ST_NORMAL;
    end else begin
      fim_q   <= fim;
      sel_q   <= sel;
      novo_q  <= captura;
      sel_r_q <= sel_r_d;
      if (captura) cnt_q[tipo] <= (cnt_q[tipo] == 4'd9) ? 4'd0 : cnt_q[tipo] + 4'd1;
      case (state_q)
        ST_NORMAL: begin
          if (captura) begin
            state_q     <= ST_DESTAQUE;
            tipo_dest_q <= tipo;
            timer_q     <= TIMER_LOAD;
          end
        end
        ST_DESTAQUE: begin
          // A new capture restarts the full dwell on the new class.
          if (captura) begin
            tipo_dest_q <= tipo;
            timer_q     <= TIMER_LOAD;
          end else if (timer_q == '0) begin
            state_q <= ST_NORMAL;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= ST_NORMAL;
      endcase
    end
  end

  assign tipo_exibido = (state_q == ST_DESTAQUE) ? tipo_dest_q : sel_r_q;
  assign digito       = cnt_q[tipo_exibido];
  assign novo         = novo_q;

  decod_7seg u_decod (
    .digit_i (digito),
    .seg_o   (display)
  );

endmodule

// File: tb/tb_tp_placar.sv
// Self-checking bench for tp_placar: behavioural score model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tp_placar;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fim = 1'b0;
  logic [1:0] tipo = 2'b00;
  logic       sel = 1'b0;
  logic [6:0] display;
  logic [1:0] tipo_exibido;
  logic       novo;

  always #5 clk = ~clk;

  tp_placar #(.DESTAQUE_CICLOS(8), .ROT_CICLOS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .fim          (fim),
    .tipo         (tipo),
    .sel          (sel),
    .display      (display),
    .tipo_exibido (tipo_exibido),
    .novo         (novo)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] seg_exp(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts per class, selection, remaining highlight cycles.
  int         m_cnt [4];
  int         m_sel, m_dwell, m_dest, m_cls;
  bit         m_novo, m_fim_p, m_sel_p, m_ok;
  logic [1:0] exp_q [$];
  logic [1:0] popped;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_sel = 0; m_dwell = 0; m_dest = 0; m_novo = 0;
      m_fim_p = 0; m_sel_p = 0; m_ok = 1;
      exp_q.delete();
    end else if (m_ok) begin
      m_novo = fim && !m_fim_p;
      if (m_novo) begin
        m_cnt[tipo] = (m_cnt[tipo] + 1) % 10;
        m_dwell = 8;
        m_dest = int'(tipo);
        exp_q.push_back(tipo);
      end else if (m_dwell > 0) begin
        m_dwell = m_dwell - 1;
      end
      if (sel && !m_sel_p) m_sel = (m_sel + 1) % 4;
      m_fim_p = fim;
      m_sel_p = sel;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      m_cls = (m_dwell > 0) ? m_dest : m_sel;
      chk("tipo_exibido", 32'(tipo_exibido), 32'(m_cls));
      chk("novo", 32'(novo), 32'(m_novo));
      chk("display", 32'(display), 32'(seg_exp(m_cnt[m_cls])));
      if (novo === 1'b1) begin
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          chk("novo_tipo", 32'(tipo_exibido), 32'(popped));
        end else begin
          chk("novo_unexpected", 32'(novo), 32'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         n_cls, n_novo;
  logic [1:0] sel_seq [4];

  initial begin
    sel_seq = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset then idle.
    tick(); tick();
    reset = 1'b0;
    n_novo = 0;
    repeat (20) begin
      if (novo === 1'b1) n_novo++;
      tick();
    end
    chk("idle_display", 32'(display), 32'(7'b1000000));
    chk("idle_tipo", 32'(tipo_exibido), 32'(2'b00));
    chk("idle_novo_count", 32'(n_novo), 32'(0));

    // Adjective capture, fim held high, tipo changes mid-hold.
    tipo = 2'b01; fim = 1'b1;
    tick();
    n_cls = 0; n_novo = 0;
    for (int i = 0; i < 30; i++) begin
      if (tipo_exibido == 2'b01) begin
        n_cls++;
        chk("dwell_seg", 32'(display), 32'(7'b1111001));
      end
      if (novo === 1'b1) n_novo++;
      if (i == 3) tipo = 2'b11;
      tick();
    end
    chk("dwell_len", 32'(n_cls), 32'(8));
    chk("novo_once", 32'(n_novo), 32'(1));
    chk("after_dwell_tipo", 32'(tipo_exibido), 32'(2'b00));

    // One error result then ten adverbs: adverb counter wraps.
    fim = 1'b0; tick();
    tipo = 2'b00; fim = 1'b1; tick();
    chk("nulo_seg", 32'(display), 32'(7'b1111001));
    for (int k = 1; k <= 10; k++) begin
      fim = 1'b0; tick();
      tipo = 2'b11; fim = 1'b1; tick();
      chk("adv_seg", 32'(display), 32'(seg_exp(k % 10)));
    end
    chk("adv_wrap_seg", 32'(display), 32'(7'b1000000));
    chk("model_cnt_adv", 32'(m_cnt[3]), 32'(0));
    chk("model_cnt_nulo", 32'(m_cnt[0]), 32'(1));

    // Selection stepping, held button counts once.
    fim = 1'b0;
    repeat (12) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int e = 0; e < 4; e++) begin
      sel = 1'b1; tick();
      chk("sel_step", 32'(tipo_exibido), 32'(sel_seq[e]));
      tick(); tick();
      chk("sel_hold", 32'(tipo_exibido), 32'(sel_seq[e]));
      sel = 1'b0; tick();
    end

    // Second capture restarts the dwell on the new class.
    tipo = 2'b10; fim = 1'b1; tick();
    chk("first_cls", 32'(tipo_exibido), 32'(2'b10));
    fim = 1'b0; tick(); tick(); tick();
    chk("first_cls_hold", 32'(tipo_exibido), 32'(2'b10));
    tipo = 2'b01; fim = 1'b1; tick();
    chk("second_cls", 32'(tipo_exibido), 32'(2'b01));
    n_cls = 1;
    repeat (12) begin
      tick();
      if (tipo_exibido == 2'b01) n_cls++;
    end
    chk("second_dwell_len", 32'(n_cls), 32'(8));

    // Reset mid-dwell.
    fim = 1'b0; tick();
    tipo = 2'b11; fim = 1'b1; tick(); tick(); tick();
    reset = 1'b1; tick();
    chk("rst_display", 32'(display), 32'(7'b1000000));
    chk("rst_tipo", 32'(tipo_exibido), 32'(2'b00));
    chk("rst_novo", 32'(novo), 32'(1'b0));
    reset = 1'b0; fim = 1'b0; tick();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) fim = ~fim;
      if ($urandom_range(0, 2) == 0) sel = ~sel;
      if ($urandom_range(0, 1) == 1) tipo = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0; fim = 1'b0; sel = 1'b0;
    repeat (3) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
